// File: rtl/ucsbece154b_bpred_ctrl_pkg.sv
// Shared opcodes, sequencer states and opcode classification helpers for the
// branch predictor control slice.
package ucsbece154b_bpred_ctrl_pkg;

    localparam logic [6:0] INSTR_BRANCH_OP = 7'b1100011;
    localparam logic [6:0] INSTR_JAL_OP    = 7'b1101111;
    localparam logic [6:0] INSTR_JALR_OP   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } bpred_state_e;

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == INSTR_BRANCH_OP) || (op == INSTR_JAL_OP) || (op == INSTR_JALR_OP);
    endfunction

endpackage

// File: rtl/ucsbece154b_bpred_ctrl_if.sv
// Predictor-facing bundle: fetch-time prediction in, BTB/PHT/GHR write port out.
// The controller owns the write port (master); the predictor is the slave.
interface ucsbece154b_bpred_ctrl_if #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
);
    localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);

    logic                    BranchTaken_i;
    logic [31:0]             BTBtarget_i;
    logic [NUM_GHR_BITS-1:0] PHTreadaddress_i;
    logic                    BTB_we_o;
    logic [IDX_W-1:0]        BTBwriteaddress_o;
    logic [31:0]             BTBwritedata_o;
    logic                    PHTwe_o;
    logic                    PHTincrement_o;
    logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
    logic                    GHRreset_o;

    modport master (
        input  BranchTaken_i, BTBtarget_i, PHTreadaddress_i,
        output BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
               PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o
    );

    modport slave (
        output BranchTaken_i, BTBtarget_i, PHTreadaddress_i,
        input  BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
               PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o
    );
endinterface

// File: rtl/ucsbece154b_bpred_ctrl_chk.sv
// Protocol checker: the hazard unit must never let an update arrive while the
// queue is full and not draining.
module ucsbece154b_bpred_ctrl_chk (
    input logic clk,
    input logic reset_i,
    input logic push,
    input logic pop,
    input logic full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset_i) !(push && full && !pop));
endmodule

// File: rtl/ucsbece154b_bpred_updq.sv
// Small synchronous FIFO holding pending predictor updates; head is a direct
// register read so the write port sees only registered data.
module ucsbece154b_bpred_updq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s, pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];

    // Entry storage
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/ucsbece154b_bpred_ctrl.sv
// Predictor sequencer: pipes fetch predictions to Execute, detects mispredicts,
// and drains queued BTB/PHT updates one per cycle.
module ucsbece154b_bpred_ctrl
    import ucsbece154b_bpred_ctrl_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int UPDQ_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        StallF_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        FlushE_i,
    input  logic [6:0]  opE_i,
    input  logic [31:0] pcE_i,
    input  logic [31:0] PCPlus4E_i,
    input  logic        TakenE_i,
    input  logic [31:0] TargetE_i,
    output logic        MispredictE_o,
    output logic [31:0] RedirectPC_o,
    output logic        FlushD_o,
    output logic        FlushE_o,
    output logic        StallF_o,
    ucsbece154b_bpred_ctrl_if.master bp
);
    localparam int IDX_W   = $clog2(NUM_BTB_ENTRIES);
    localparam int ENTRY_W = 3 + IDX_W + NUM_GHR_BITS + 32;

    bpred_state_e            state_r, state_next_s;
    logic                    d_valid_r, d_taken_r, e_valid_r, e_taken_r;
    logic [31:0]             d_target_r, e_target_r;
    logic [NUM_GHR_BITS-1:0] d_pht_r, e_pht_r;
    logic                    mispredict_s, enq_s, deq_s, q_full_s, q_empty_s;
    logic                    init_s, ghr_reset_s;
    logic [ENTRY_W-1:0]      enq_data_s, head_s;
    logic                    head_btb_w_s, head_pht_w_s, head_inc_s;
    logic [IDX_W-1:0]        head_idx_s;
    logic [NUM_GHR_BITS-1:0] head_pht_s;
    logic [31:0]             head_tgt_s;
    logic                    unused_s;

    assign {head_btb_w_s, head_pht_w_s, head_inc_s, head_idx_s, head_pht_s, head_tgt_s} = head_s;
    assign unused_s = ^{pcE_i[31:IDX_W+2], pcE_i[1:0]};

    // State register
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) state_r <= ST_INIT;
        else         state_r <= state_next_s;
    end

    // Next state: a mispredict during recovery simply extends recovery
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT:             state_next_s = ST_RUN;
            ST_RUN, ST_RECOVER:  state_next_s = mispredict_s ? ST_RECOVER : ST_RUN;
            default:             state_next_s = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        init_s      = 1'b0;
        ghr_reset_s = 1'b0;
        case (state_r)
            ST_INIT:    begin init_s = 1'b1; ghr_reset_s = 1'b1; end
            ST_RUN:     begin init_s = 1'b0; ghr_reset_s = 1'b0; end
            ST_RECOVER: begin init_s = 1'b0; ghr_reset_s = 1'b1; end
            default:    begin init_s = 1'b1; ghr_reset_s = 1'b1; end
        endcase
    end

    // F->D metadata; flush beats stall
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            d_valid_r  <= 1'b0;
            d_taken_r  <= 1'b0;
            d_target_r <= 32'd0;
            d_pht_r    <= {NUM_GHR_BITS{1'b0}};
        end else if (FlushD_i) begin
            d_valid_r  <= 1'b0;
        end else if (!StallF_i) begin
            d_valid_r  <= 1'b1;
            d_taken_r  <= bp.BranchTaken_i;
            d_target_r <= bp.BTBtarget_i;
            d_pht_r    <= bp.PHTreadaddress_i;
        end
    end

    // D->E metadata; flush beats stall
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            e_valid_r  <= 1'b0;
            e_taken_r  <= 1'b0;
            e_target_r <= 32'd0;
            e_pht_r    <= {NUM_GHR_BITS{1'b0}};
        end else if (FlushE_i) begin
            e_valid_r  <= 1'b0;
        end else if (!StallD_i) begin
            e_valid_r  <= d_valid_r;
            e_taken_r  <= d_taken_r;
            e_target_r <= d_target_r;
            e_pht_r    <= d_pht_r;
        end
    end

    // Prediction check against the resolved outcome in Execute
    always_comb begin
        mispredict_s = 1'b0;
        if (e_valid_r && (state_r != ST_INIT)) begin
            case (opE_i)
                INSTR_BRANCH_OP: mispredict_s = (e_taken_r != TakenE_i) ||
                                                (e_taken_r && TakenE_i && (e_target_r != TargetE_i));
                INSTR_JAL_OP,
                INSTR_JALR_OP:   mispredict_s = !e_taken_r || (e_target_r != TargetE_i);
                default:         mispredict_s = e_taken_r;
            endcase
        end else begin
            mispredict_s = 1'b0;
        end
    end

    assign enq_s      = e_valid_r & is_ctrl_op(opE_i) & ~FlushE_i;
    assign deq_s      = (state_r == ST_RUN) & ~q_empty_s;
    assign enq_data_s = {mispredict_s & TakenE_i, opE_i == INSTR_BRANCH_OP, TakenE_i,
                         pcE_i[IDX_W+1:2], e_pht_r, TargetE_i};

    ucsbece154b_bpred_updq #(.WIDTH(ENTRY_W), .DEPTH(UPDQ_DEPTH)) u_updq (
        .clk     (clk),
        .reset_i (reset_i),
        .push    (enq_s),
        .pop     (deq_s),
        .din     (enq_data_s),
        .full    (q_full_s),
        .empty   (q_empty_s),
        .head    (head_s)
    );

    ucsbece154b_bpred_ctrl_chk u_chk (
        .clk     (clk),
        .reset_i (reset_i),
        .push    (enq_s),
        .pop     (deq_s),
        .full    (q_full_s)
    );

    assign MispredictE_o = mispredict_s;
    assign RedirectPC_o  = TakenE_i ? TargetE_i : PCPlus4E_i;
    assign FlushD_o      = mispredict_s;
    assign FlushE_o      = mispredict_s;
    assign StallF_o      = init_s | (q_full_s & ~deq_s);

    assign bp.GHRreset_o        = ghr_reset_s;
    assign bp.BTB_we_o          = deq_s & head_btb_w_s;
    assign bp.PHTwe_o           = deq_s & head_pht_w_s;
    assign bp.PHTincrement_o    = deq_s & head_inc_s;
    assign bp.BTBwriteaddress_o = deq_s ? head_idx_s : {IDX_W{1'b0}};
    assign bp.BTBwritedata_o    = deq_s ? head_tgt_s : 32'd0;
    assign bp.PHTwriteaddress_o = deq_s ? head_pht_s : {NUM_GHR_BITS{1'b0}};
endmodule

// File: tb/tb_ucsbece154b_bpred_ctrl.sv
// Bench for the predictor sequencer: directed scenarios then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_ucsbece154b_bpred_ctrl;
    localparam int NB = 32;
    localparam int NG = 5;
    localparam int QD = 2;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_ALU  = 7'h33;
    localparam logic [6:0] OP_NOP  = 7'h13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, StallF_i, StallD_i, FlushD_i, FlushE_i, TakenE_i;
    logic [6:0]  opE_i;
    logic [31:0] pcE_i, PCPlus4E_i, TargetE_i, RedirectPC_o;
    logic        MispredictE_o, FlushD_o, FlushE_o, StallF_o;

    ucsbece154b_bpred_ctrl_if #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(NG)) bp ();

    ucsbece154b_bpred_ctrl #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(NG), .UPDQ_DEPTH(QD)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .StallF_i      (StallF_i),
        .StallD_i      (StallD_i),
        .FlushD_i      (FlushD_i),
        .FlushE_i      (FlushE_i),
        .opE_i         (opE_i),
        .pcE_i         (pcE_i),
        .PCPlus4E_i    (PCPlus4E_i),
        .TakenE_i      (TakenE_i),
        .TargetE_i     (TargetE_i),
        .MispredictE_o (MispredictE_o),
        .RedirectPC_o  (RedirectPC_o),
        .FlushD_o      (FlushD_o),
        .FlushE_o      (FlushE_o),
        .StallF_o      (StallF_o),
        .bp            (bp)
    );

    typedef struct packed {
        logic        v;
        logic        t;
        logic [31:0] tgt;
        logic [4:0]  pht;
    } meta_t;

    typedef struct packed {
        logic        btb_w;
        logic        pht_w;
        logic        inc;
        logic [4:0]  idx;
        logic [4:0]  pht;
        logic [31:0] tgt;
    } upd_t;

    // Reference model: phase 0 = init, 1 = running, 2 = recovering
    upd_t  q[$];
    meta_t md, me;
    int    phase;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic model_mis();
        if (!me.v || phase == 0) return 1'b0;
        if (opE_i == OP_BR)
            return (me.t != TakenE_i) || (me.t && TakenE_i && me.tgt != TargetE_i);
        if (opE_i == OP_JAL || opE_i == OP_JALR)
            return !me.t || (me.tgt != TargetE_i);
        return me.t;
    endfunction

    function automatic logic model_deq();
        return (phase == 1) && (q.size() > 0);
    endfunction

    task automatic check_outputs();
        logic mis, deq;
        upd_t h;
        mis = model_mis();
        deq = model_deq();
        h = deq ? q[0] : '0;
        chk("mispredict", {31'd0, MispredictE_o}, {31'd0, mis});
        chk("redirect",   RedirectPC_o, TakenE_i ? TargetE_i : PCPlus4E_i);
        chk("flushD",     {31'd0, FlushD_o}, {31'd0, mis});
        chk("flushE",     {31'd0, FlushE_o}, {31'd0, mis});
        chk("stallF",     {31'd0, StallF_o}, {31'd0, (phase == 0) || (q.size() == QD && !deq)});
        chk("ghr_reset",  {31'd0, bp.GHRreset_o}, {31'd0, phase != 1});
        chk("btb_we",     {31'd0, bp.BTB_we_o}, {31'd0, h.btb_w});
        chk("btb_addr",   {27'd0, bp.BTBwriteaddress_o}, {27'd0, h.idx});
        chk("btb_data",   bp.BTBwritedata_o, h.tgt);
        chk("pht_we",     {31'd0, bp.PHTwe_o}, {31'd0, h.pht_w});
        chk("pht_inc",    {31'd0, bp.PHTincrement_o}, {31'd0, h.inc});
        chk("pht_addr",   {27'd0, bp.PHTwriteaddress_o}, {27'd0, h.pht});
    endtask

    task automatic advance();
        logic mis, deq, enq;
        upd_t u;
        mis = model_mis();
        deq = model_deq();
        enq = me.v && is_ctrl(opE_i) && !FlushE_i;
        u.btb_w = mis && TakenE_i;
        u.pht_w = (opE_i == OP_BR);
        u.inc   = TakenE_i;
        u.idx   = 5'((pcE_i >> 2) % NB);
        u.pht   = me.pht;
        u.tgt   = TargetE_i;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back(u);
        if (phase == 0) phase = 1;
        else phase = mis ? 2 : 1;
        if (FlushE_i) me.v = 1'b0;
        else if (!StallD_i) me = md;
        if (FlushD_i) md.v = 1'b0;
        else if (!StallF_i) md = '{1'b1, bp.BranchTaken_i, bp.BTBtarget_i, bp.PHTreadaddress_i};
        #1;
    endtask

    task automatic post();
        check_outputs();
        advance();
    endtask

    task automatic cyc();
        #1;
        post();
    endtask

    task automatic set_fetch(input logic t, input logic [31:0] tgt, input logic [4:0] pht);
        bp.BranchTaken_i    = t;
        bp.BTBtarget_i      = tgt;
        bp.PHTreadaddress_i = pht;
    endtask

    task automatic set_exec(input logic [6:0] op, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        opE_i      = op;
        pcE_i      = pc;
        PCPlus4E_i = pc + 32'd4;
        TakenE_i   = tk;
        TargetE_i  = tgt;
    endtask

    task automatic idle();
        set_fetch(1'b0, 32'd0, 5'd0);
        set_exec(OP_NOP, 32'h100, 1'b0, 32'd0);
        StallF_i = 1'b0; StallD_i = 1'b0; FlushD_i = 1'b0; FlushE_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle();
        PCPlus4E_i = 32'd0;
        q.delete();
        md = '0; me = '0; phase = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_i = 1'b0;
    endtask

    initial begin
        logic [31:0] tsel [3];
        tsel[0] = 32'h40; tsel[1] = 32'h80; tsel[2] = 32'hC0;

        // Reset and the single INIT cycle
        do_reset();
        idle(); #1;
        chk("t1_init_ghr", {31'd0, bp.GHRreset_o}, 32'd1);
        chk("t1_init_stall", {31'd0, StallF_o}, 32'd1);
        post();
        idle(); set_fetch(1'b0, 32'd0, 5'd3); #1;
        chk("t1_run_ghr", {31'd0, bp.GHRreset_o}, 32'd0);
        chk("t1_run_stall", {31'd0, StallF_o}, 32'd0);
        post();

        // beq predicted not-taken, resolves taken to 0x40
        idle(); cyc();
        idle(); set_exec(OP_BR, 32'h20, 1'b1, 32'h40); #1;
        chk("t2_mis", {31'd0, MispredictE_o}, 32'd1);
        chk("t2_redirect", RedirectPC_o, 32'h40);
        chk("t2_flush", {30'd0, FlushD_o, FlushE_o}, 32'd3);
        post();
        idle(); #1;
        chk("t2_recover_ghr", {31'd0, bp.GHRreset_o}, 32'd1);
        chk("t2_recover_nowrite", {30'd0, bp.BTB_we_o, bp.PHTwe_o}, 32'd0);
        post();
        idle(); set_fetch(1'b1, 32'h40, 5'd7); #1;
        chk("t2_btb_we", {31'd0, bp.BTB_we_o}, 32'd1);
        chk("t2_btb_data", bp.BTBwritedata_o, 32'h40);
        chk("t2_pht_inc", {30'd0, bp.PHTwe_o, bp.PHTincrement_o}, 32'd3);
        post();

        // beq predicted taken to 0x40 and correct
        idle(); cyc();
        idle(); set_exec(OP_BR, 32'h30, 1'b1, 32'h40); #1;
        chk("t3_nomis", {31'd0, MispredictE_o}, 32'd0);
        post();
        idle(); #1;
        chk("t3_pht", {30'd0, bp.PHTwe_o, bp.PHTincrement_o}, 32'd3);
        chk("t3_nobtb", {31'd0, bp.BTB_we_o}, 32'd0);
        post();

        // jal at 0x10 seen for the first time
        idle(); cyc();
        idle(); cyc();
        idle(); set_exec(OP_JAL, 32'h10, 1'b1, 32'h100); #1;
        chk("t4_mis", {31'd0, MispredictE_o}, 32'd1);
        chk("t4_redirect", RedirectPC_o, 32'h100);
        post();
        idle(); cyc();
        idle(); #1;
        chk("t4_btb_addr", {27'd0, bp.BTBwriteaddress_o}, 32'd4);
        chk("t4_we", {30'd0, bp.BTB_we_o, bp.PHTwe_o}, 32'd2);
        post();

        // Two mispredicting branches back to back while recovery blocks the drain
        idle(); cyc();
        idle(); cyc();
        idle(); set_exec(OP_BR, 32'h44, 1'b1, 32'h80); cyc();
        idle(); set_exec(OP_BR, 32'h48, 1'b1, 32'h88); cyc();
        idle(); #1;
        chk("t5_full_stall", {31'd0, StallF_o}, 32'd1);
        post();
        idle(); #1;
        chk("t5_first_addr", {27'd0, bp.BTBwriteaddress_o}, 32'd17);
        chk("t5_first_data", bp.BTBwritedata_o, 32'h80);
        post();
        idle(); #1;
        chk("t5_second_addr", {27'd0, bp.BTBwriteaddress_o}, 32'd18);
        chk("t5_second_data", bp.BTBwritedata_o, 32'h88);
        post();

        // Reset with two entries pending
        idle(); cyc();
        idle(); cyc();
        idle(); set_exec(OP_BR, 32'h50, 1'b1, 32'hC0); cyc();
        idle(); set_exec(OP_BR, 32'h54, 1'b1, 32'hC4); cyc();
        do_reset();
        idle(); #1;
        chk("t6_init_ghr", {31'd0, bp.GHRreset_o}, 32'd1);
        post();
        for (int i = 0; i < 4; i++) begin
            idle(); #1;
            chk("t6_no_strobe", {30'd0, bp.BTB_we_o, bp.PHTwe_o}, 32'd0);
            post();
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            int r;
            r = int'($urandom_range(0, 4));
            op = (r == 0) ? OP_BR : (r == 1) ? OP_JAL : (r == 2) ? OP_JALR : (r == 3) ? OP_ALU : OP_NOP;
            set_fetch(1'($urandom_range(0, 1)), tsel[$urandom_range(0, 2)], 5'($urandom_range(0, 31)));
            set_exec(op, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                     (op == OP_JAL || op == OP_JALR) ? 1'b1 : 1'($urandom_range(0, 1)),
                     tsel[$urandom_range(0, 2)]);
            StallF_i = ($urandom_range(0, 9) == 0);
            StallD_i = ($urandom_range(0, 9) == 0);
            FlushD_i = ($urandom_range(0, 9) == 0);
            FlushE_i = ($urandom_range(0, 9) == 0);
            if (me.v && is_ctrl(op) && q.size() == QD && !model_deq()) FlushE_i = 1'b1;
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
